// File: rtl/decoder24_enable_low_seq.sv
// Active-low 2-to-4 decoder with a registered sequencer.
// A load strobe gives a timed one-cold pulse; scan mode steps through codes 0..3 continuously.
module decoder24_enable_low_seq #(
    parameter int PULSE_LEN = 4,
    parameter int DWELL     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic [1:0] y,
    input  logic       load,
    input  logic       scan_mode,
    output logic [3:0] w,
    output logic [1:0] code_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        SCAN  = 2'd2
    } state_t;

    // The counter counts edges since entry, so the last legal value is LEN-1.
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_LEN - 1);
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [1:0] code_q, code_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] w_q, w_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (e) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan_mode) begin
                        state_d = SCAN;
                        code_d  = 2'd0;
                        cnt_d   = 8'd0;
                    end else if (load) begin
                        state_d = PULSE;
                        code_d  = y;
                        cnt_d   = 8'd0;
                    end
                end
                PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                SCAN: begin
                    if (!scan_mode) begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == DWELL_LAST) begin
                        code_d = code_q + 2'd1;
                        cnt_d  = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end

        // Outputs are derived from the next state so they register alongside it.
        busy_d = (state_d != IDLE);
        w_d    = busy_d ? ~(4'b0001 << code_d) : 4'b1111;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= 2'd0;
            cnt_q   <= 8'd0;
            w_q     <= 4'b1111;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign w        = w_q;
    assign code_out = code_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_decoder24_enable_low_seq.sv
// Directed, table-driven bench for decoder24_enable_low_seq with default parameters.
module tb_decoder24_enable_low_seq;

    logic       clk;
    logic       rst;
    logic       e;
    logic [1:0] y;
    logic       load;
    logic       scan_mode;
    logic [3:0] w;
    logic [1:0] code_out;
    logic       busy;
    logic       done;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        string      name;
        logic       e;
        logic [1:0] y;
        logic       load;
        logic       scan;
        logic [3:0] expW;
        logic [1:0] expCode;
        logic       expBusy;
        logic       expDone;
    } vec_t;

    vec_t vecs[$];

    decoder24_enable_low_seq #(.PULSE_LEN(4), .DWELL(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .e         (e),
        .y         (y),
        .load      (load),
        .scan_mode (scan_mode),
        .w         (w),
        .code_out  (code_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs just after an edge, then advance one edge and settle
    task automatic applyStimulus(input logic ie, input logic [1:0] iy, input logic il, input logic is);
        e = ie;
        y = iy;
        load = il;
        scan_mode = is;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ew, input logic [1:0] ec,
                               input logic eb, input logic ed);
        assertCount++;
        if ({w, code_out, busy, done} !== {ew, ec, eb, ed}) begin
            failCount++;
            $display("[TB] FAIL %s: got w=%b code=%0d busy=%b done=%b, expected w=%b code=%0d busy=%b done=%b",
                     name, w, code_out, busy, done, ew, ec, eb, ed);
        end
    endtask

    function automatic vec_t mk(string n, logic ie, logic [1:0] iy, logic il, logic is,
                                logic [3:0] ew, logic [1:0] ec, logic eb, logic ed);
        vec_t v;
        v.name = n; v.e = ie; v.y = iy; v.load = il; v.scan = is;
        v.expW = ew; v.expCode = ec; v.expBusy = eb; v.expDone = ed;
        return v;
    endfunction

    initial begin
        logic [1:0] expCode;

        // Basic pulse of code 2
        vecs.push_back(mk("p2_enter", 0, 2, 1, 0, 4'b1011, 2, 1, 0));
        vecs.push_back(mk("p2_hold1", 0, 0, 0, 0, 4'b1011, 2, 1, 0));
        vecs.push_back(mk("p2_hold2", 0, 0, 0, 0, 4'b1011, 2, 1, 0));
        vecs.push_back(mk("p2_hold3", 0, 0, 0, 0, 4'b1011, 2, 1, 0));
        vecs.push_back(mk("p2_done",  0, 0, 0, 0, 4'b1111, 2, 0, 1));
        vecs.push_back(mk("p2_idle",  0, 0, 0, 0, 4'b1111, 2, 0, 0));
        // Pulse of code 1 ignores a reload and a scan request mid-pulse
        vecs.push_back(mk("p1_enter",  0, 1, 1, 0, 4'b1101, 1, 1, 0));
        vecs.push_back(mk("p1_reload", 0, 3, 1, 0, 4'b1101, 1, 1, 0));
        vecs.push_back(mk("p1_scanig", 0, 3, 0, 1, 4'b1101, 1, 1, 0));
        vecs.push_back(mk("p1_hold",   0, 0, 0, 0, 4'b1101, 1, 1, 0));
        vecs.push_back(mk("p1_done",   0, 0, 0, 0, 4'b1111, 1, 0, 1));
        vecs.push_back(mk("p1_idle",   0, 0, 0, 0, 4'b1111, 1, 0, 0));
        // e=1 dominates every request while idle
        vecs.push_back(mk("dis_idle",  1, 3, 1, 1, 4'b1111, 1, 0, 0));
        // Scan wins over a simultaneous load, exit without done
        vecs.push_back(mk("scan_win",  0, 3, 1, 1, 4'b1110, 0, 1, 0));
        vecs.push_back(mk("scan_exit", 0, 3, 0, 0, 4'b1111, 0, 0, 0));
        vecs.push_back(mk("scan_post", 0, 0, 0, 0, 4'b1111, 0, 0, 0));

        rst = 1'b1; e = 1'b1; y = 2'd0; load = 1'b0; scan_mode = 1'b0;
        #2;
        checkOutput("reset_async", 4'b1111, 0, 0, 0);
        e = 1'b0; load = 1'b1; scan_mode = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset_hold_inputs", 4'b1111, 0, 0, 0);
        load = 1'b0; scan_mode = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].e, vecs[i].y, vecs[i].load, vecs[i].scan);
            checkOutput(vecs[i].name, vecs[i].expW, vecs[i].expCode, vecs[i].expBusy, vecs[i].expDone);
        end

        // 40-cycle scan: code advances every 8 cycles and wraps 3 -> 0
        for (int k = 0; k < 40; k++) begin
            applyStimulus(0, 0, 0, 1);
            expCode = 2'((k / 8) % 4);
            checkOutput($sformatf("scan_k%0d", k), ~(4'b0001 << expCode), expCode, 1, 0);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("scan40_exit", 4'b1111, 0, 0, 0);

        // Enable abort mid-pulse, then a normal pulse of code 0
        applyStimulus(0, 2, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("abort_pre", 4'b1011, 2, 1, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("abort_edge", 4'b1111, 2, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("abort_nodone", 4'b1111, 2, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("abort_reload", 4'b1110, 0, 1, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("abort_reload_done", 4'b1111, 0, 0, 1);

        // Asynchronous reset mid-scan at code 2
        for (int k = 0; k < 17; k++) applyStimulus(0, 0, 0, 1);
        checkOutput("rscan_code2", 4'b1011, 2, 1, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rscan_async", 4'b1111, 0, 0, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("rscan_held", 4'b1111, 0, 0, 0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1);
        checkOutput("rscan_reenter", 4'b1110, 0, 1, 0);

        // Reset mid-pulse gives no done afterwards
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 3, 1, 0);
        checkOutput("rpulse_enter", 4'b0111, 3, 1, 0);
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        checkOutput("rpulse_async", 4'b1111, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("rpulse_nodone%0d", k), 4'b1111, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/decoder24_enable_low_seq.md
DECODER24_ENABLE_LOW_SEQ -- requirements
Module: decoder24_enable_low_seq

Interface
REQ-001 Parameter PULSE_LEN, default 4, number of cycles a loaded code drives its output line (legal range 1..255).
REQ-002 Parameter DWELL, default 8, number of cycles each code is held in scan mode (legal range 1..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 e  input  1  enable, active-low; 1 disables the block.
REQ-006 y  input  2  binary code to decode (0..3).
REQ-007 load  input  1  single-cycle strobe; requests a timed pulse of code y.
REQ-008 scan_mode  input  1  level; 1 requests continuous scan through codes 0..3.
REQ-009 w  output  4  decoded lines, active-low, one-cold: code n drives w[n]=0, all other bits 1; idle value 4'b1111.
REQ-010 code_out  output  2  code currently being driven on w.
REQ-011 busy  output  1  high while any line of w is driven low.
REQ-012 done  output  1  one-cycle pulse when a load pulse completes normally.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 The FSM SHALL have exactly three states: IDLE, PULSE, SCAN.
REQ-015 IDLE: w=4'b1111, busy=0; code_out holds its last value.
REQ-016 IDLE->SCAN at an edge where e=0 and scan_mode=1; after that edge code_out=0, w=4'b1110, busy=1, dwell counter cleared.
REQ-017 IDLE->PULSE at an edge where e=0, scan_mode=0, load=1; after that edge code_out=y (sampled), w=one-cold(y), busy=1, pulse counter cleared.
REQ-018 scan_mode=1 and load=1 at the same edge: scan SHALL win; load is dropped.
REQ-019 PULSE: w SHALL stay at one-cold(code_out) for exactly PULSE_LEN cycles, counted from the edge that entered PULSE.
REQ-020 PULSE expiry: at edge PULSE_LEN after entry, state->IDLE, w=4'b1111, busy=0, done=1 for exactly one cycle.
REQ-021 load, y and scan_mode changes during PULSE SHALL be ignored (no restart, no re-latch).
REQ-022 SCAN: every DWELL cycles code_out SHALL increment by 1 modulo 4 (3 wraps to 0), w following it at the same edge.
REQ-023 SCAN exit: at the first edge where scan_mode=0, state->IDLE, w=4'b1111, busy=0; done SHALL NOT pulse.
REQ-024 Enable abort: at any edge where e=1, from any state, state->IDLE, w=4'b1111, busy=0, done=0, counters cleared; e=1 has priority over all other inputs.
REQ-025 done SHALL be 0 in every cycle except the one defined in REQ-020.
REQ-026 Exactly one bit of w SHALL be 0 whenever busy=1; w SHALL be 4'b1111 whenever busy=0.
REQ-027 Counters SHALL be 8 bits wide; no counter SHALL overflow for legal parameter values.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, force state=IDLE, w=4'b1111, code_out=2'b00, busy=0, done=0, all counters 0.
REQ-029 While rst=1, load, scan_mode and e SHALL have no effect.
REQ-030 Reset asserted mid-PULSE or mid-SCAN SHALL abort with no done pulse; the first edge after release SHALL evaluate IDLE transitions normally.

Verification
REQ-031 Reset then e=0, y=2, load pulse -> next cycle w=4'b1011, code_out=2, busy=1 for 4 cycles; then w=4'b1111, busy=0, done=1 for one cycle.
REQ-032 e=0, scan_mode=1 held for 40 cycles -> w sequence 1110,1101,1011,0111,1110, each held 8 cycles; busy=1 throughout; done never 1.
REQ-033 During PULSE with y=1, a second load with y=3 at cycle 2 -> ignored; w stays 4'b1101 for the full 4 cycles, single done.
REQ-034 Mid-PULSE e driven to 1 -> next edge w=4'b1111, busy=0, done stays 0; subsequent e=0 with load y=0 -> w=4'b1110 normally.
REQ-035 load=1 and scan_mode=1 same edge with y=3 -> SCAN entered, w=4'b1110 (code 0), not 4'b0111.
REQ-036 rst asserted asynchronously mid-SCAN at code 2 -> w=4'b1111, code_out=0, busy=0 before the next clock edge.
